// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module  : lfsr_pkg
// Brief   : Shared constants and shift helpers for the XNOR Fibonacci LFSR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    localparam logic [9:0] DEFAULT_TAPS_10 = 10'b0000001001;

    // Operands are zero-extended to 32 bits; zero bits do not disturb the XNOR.
    function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] taps);
        return ~^(state & taps);
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int unsigned width);
        logic [31:0] w_next;
        w_next = state >> 1;
        w_next[width-1] = lfsr_fb(state, taps);
        return w_next;
    endfunction

    function automatic logic [31:0] all_ones(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
// ============================================================================
// Module  : lfsr_step
// Brief   : One combinational XNOR Fibonacci shift stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int              WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS_10)
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_state,
    output logic             o_bit
);

    logic w_fb;

    assign w_fb    = lfsr_fb(32'(i_state), 32'(TAPS));
    assign o_state = {w_fb, i_state[WIDTH-1:1]};
    assign o_bit   = i_state[0];

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
// Module  : lfsr_gen
// Brief   : Parametrised XNOR Fibonacci LFSR with seed load, multi-step
//           advance, serial bit bus, wrap detection and lock-up protection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS_10),
    parameter int               STEPS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] out,
    output logic [STEPS-1:0] bits_out,
    output logic             wrap,
    output logic             lockup_err
);

    localparam logic [WIDTH-1:0] c_ones = WIDTH'(all_ones(WIDTH));

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_gen: STEPS must be in 1..WIDTH");
    end
    if (TAPS[0] != 1'b1) begin : g_bad_taps
        $error("lfsr_gen: TAPS[0] must be set");
    end

    logic [WIDTH-1:0]             r_state;
    logic [WIDTH-1:0]             r_start;
    logic [STEPS-1:0]             r_bits;
    logic                         r_wrap;
    logic                         r_lockup;

    logic [STEPS:0][WIDTH-1:0]    w_chain;
    logic [STEPS-1:0]             w_bits;
    logic [STEPS-1:0]             w_hit;

    assign w_chain[0] = r_state;

    // Every intermediate state is compared, so a wrap inside a multi-step advance is caught.
    for (genvar k = 0; k < STEPS; k++) begin : g_chain
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .i_state (w_chain[k]),
            .o_state (w_chain[k+1]),
            .o_bit   (w_bits[k])
        );
        assign w_hit[k] = (w_chain[k+1] == r_start);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= '0;
            r_start  <= '0;
            r_bits   <= '0;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
            if (load) begin
                if (seed == c_ones) begin
                    r_state  <= '0;
                    r_start  <= '0;
                    r_lockup <= 1'b1;
                end else begin
                    r_state <= seed;
                    r_start <= seed;
                end
            end else if (enable) begin
                r_state <= w_chain[STEPS];
                r_bits  <= w_bits;
                r_wrap  <= |w_hit;
            end
        end
    end

    assign out        = r_state;
    assign bits_out   = r_bits;
    assign wrap       = r_wrap;
    assign lockup_err = r_lockup;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ============================================================================
// Module  : tb_lfsr_gen
// Brief   : Self-checking bench for lfsr_gen (default and STEPS=4 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_gen;

    localparam logic [9:0] c_taps = 10'b0000001001;

    typedef struct {
        string      tag;
        logic [9:0] out;
        logic       bits;
        logic       wrap;
        logic       lock;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [9:0] seed = '0;
    logic [9:0] out;
    logic [0:0] bits_out;
    logic       wrap;
    logic       lockup_err;

    logic       enable4 = 1'b0;
    logic       load4 = 1'b0;
    logic [9:0] seed4 = '0;
    logic [9:0] out4;
    logic [3:0] bits4;
    logic       wrap4;
    logic       lock4;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic [9:0] m_state = '0;
    logic [9:0] m_start = '0;
    logic       m_bits  = 1'b0;
    logic [9:0] m4_state = '0;

    always #5 clock = ~clock;

    lfsr_gen #(.WIDTH(10), .TAPS(c_taps), .STEPS(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .load(load), .seed(seed),
        .out(out), .bits_out(bits_out), .wrap(wrap), .lockup_err(lockup_err)
    );

    lfsr_gen #(.WIDTH(10), .TAPS(c_taps), .STEPS(4)) dut4 (
        .clock(clock), .reset(reset), .enable(enable4), .load(load4), .seed(seed4),
        .out(out4), .bits_out(bits4), .wrap(wrap4), .lockup_err(lock4)
    );

    function automatic logic [9:0] ref_shift(input logic [9:0] s);
        logic fb;
        fb = 1'b1;
        for (int i = 0; i < 10; i++) if (c_taps[i]) fb = fb ^ s[i];
        return {fb, s[9:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the default instance; the model result is queued and checked after the edge.
    task automatic drive(input string tag, input logic en, input logic ld, input logic [9:0] sd);
        exp_t e;
        exp_t g;
        e.tag  = tag;
        e.wrap = 1'b0;
        e.lock = 1'b0;
        if (ld) begin
            if (sd == 10'h3FF) begin
                m_state = '0;
                m_start = '0;
                e.lock  = 1'b1;
            end else begin
                m_state = sd;
                m_start = sd;
            end
        end else if (en) begin
            m_bits  = m_state[0];
            m_state = ref_shift(m_state);
            e.wrap  = (m_state == m_start);
        end
        e.out  = m_state;
        e.bits = m_bits;
        enable = en;
        load   = ld;
        seed   = sd;
        q.push_back(e);
        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            g = q.pop_front();
            chk({g.tag, ".out"},  32'(out),        32'(g.out));
            chk({g.tag, ".bits"}, 32'(bits_out),   32'(g.bits));
            chk({g.tag, ".wrap"}, 32'(wrap),       32'(g.wrap));
            chk({g.tag, ".lock"}, 32'(lockup_err), 32'(g.lock));
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, ".out"},   32'(out),        32'd0);
        chk({tag, ".bits"},  32'(bits_out),   32'd0);
        chk({tag, ".wrap"},  32'(wrap),       32'd0);
        chk({tag, ".lock"},  32'(lockup_err), 32'd0);
        chk({tag, ".out4"},  32'(out4),       32'd0);
        @(negedge clock);
        reset    = 1'b1;
        m_state  = '0;
        m_start  = '0;
        m_bits   = 1'b0;
        m4_state = '0;
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   seen [1024];
        int   wraps;
        logic [3:0] eb;
        logic       ew;

        // Reset state
        enable = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst.out",  32'(out),        32'd0);
        chk("rst.bits", 32'(bits_out),   32'd0);
        chk("rst.wrap", 32'(wrap),       32'd0);
        chk("rst.lock", 32'(lockup_err), 32'd0);
        reset = 1'b1;

        // First advances from zero, with fixed values
        drive("adv1", 1'b1, 1'b0, '0);
        chk("adv1.const", 32'(out), 32'h200);
        drive("adv2", 1'b1, 1'b0, '0);
        chk("adv2.const", 32'(out), 32'h300);
        drive("adv3", 1'b1, 1'b0, '0);
        chk("adv3.const", 32'(out), 32'h380);

        // Full period from zero: distinct states, never all-ones, a single wrap at cycle 1023
        foreach (seen[i]) seen[i] = 1'b0;
        seen[0]   = 1'b1;
        seen[10'h200] = 1'b1;
        seen[10'h300] = 1'b1;
        seen[10'h380] = 1'b1;
        wraps = 0;
        for (int c = 4; c <= 1023; c++) begin
            drive("period", 1'b1, 1'b0, '0);
            if (wrap) wraps++;
            if (c < 1023) begin
                chk("period.distinct", 32'(seen[out]), 32'd0);
                chk("period.notones",  32'(out == 10'h3FF), 32'd0);
                seen[out] = 1'b1;
            end
        end
        chk("period.wrap_at_1023", 32'(wrap), 32'd1);
        chk("period.out_at_1023",  32'(out),  32'h000);
        chk("period.wrap_count",   32'(wraps), 32'd1);

        // Load beats enable, then a full period back to the seed
        drive("load155", 1'b1, 1'b1, 10'h155);
        chk("load155.const", 32'(out), 32'h155);
        for (int c = 1; c <= 1023; c++) drive("p155", 1'b1, 1'b0, '0);
        chk("p155.wrap", 32'(wrap), 32'd1);
        chk("p155.out",  32'(out),  32'h155);

        // Asynchronous reset while wrap is high
        async_reset_check("midrst");
        drive("restart1", 1'b1, 1'b0, '0);
        chk("restart1.const", 32'(out), 32'h200);
        drive("restart2", 1'b1, 1'b0, '0);
        chk("restart2.const", 32'(out), 32'h300);

        // Lock-up seed rejection, with and without enable
        drive("lock1", 1'b1, 1'b1, 10'h3FF);
        chk("lock1.const", 32'(lockup_err), 32'd1);
        drive("lock1.next", 1'b1, 1'b0, '0);
        chk("lock1.next.const", 32'(out), 32'h200);
        drive("hold", 1'b0, 1'b0, '0);
        drive("lock2", 1'b0, 1'b1, 10'h3FF);
        async_reset_check("lockrst");

        // STEPS=4 instance: first advance and wrap on cycle 256 only
        enable = 1'b0;
        for (int c = 1; c <= 256; c++) begin
            eb = '0;
            ew = 1'b0;
            for (int s = 0; s < 4; s++) begin
                eb[s]    = m4_state[0];
                m4_state = ref_shift(m4_state);
                if (m4_state == 10'h000) ew = 1'b1;
            end
            enable4 = 1'b1;
            @(posedge clock);
            #1;
            chk("s4.out",  32'(out4),  32'(m4_state));
            chk("s4.bits", 32'(bits4), 32'(eb));
            chk("s4.wrap", 32'(wrap4), 32'(ew));
            if (c == 1) begin
                chk("s4.first.out",  32'(out4),  32'h3C0);
                chk("s4.first.bits", 32'(bits4), 32'h0);
            end
            if (c == 256) chk("s4.wrap256", 32'(wrap4), 32'd1);
        end
        enable4 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised XNOR Fibonacci LFSR: the next-generation pseudo-random source for the game-of-life board and other random-seed consumers. Width, tap mask and steps-per-clock are parameters. Adds over the fixed 10-bit generator:
- seed load,
- clock enable,
- multi-step advance,
- a serial output bus,
- sequence-wrap detection,
- lock-up state protection.

## Interface
Parameters:
- WIDTH, 10, register width; legal range 3..32
- TAPS, 10'b0000001001, feedback tap mask (bit i set = out[i] tapped); TAPS[0] must be 1
- STEPS, 1, LFSR shifts per enabled clock; legal range 1..WIDTH

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  advance STEPS shifts this cycle
- load  in  1  load seed this cycle
- seed  in  WIDTH  value for load
- out  out  WIDTH  current LFSR state
- bits_out  out  STEPS  bits shifted out by last advance; bit i = out[0] before shift i
- wrap  out  1  one-cycle pulse: last advance passed through the start state
- lockup_err  out  1  one-cycle pulse: illegal all-ones seed rejected

## Operation
- One shift:
  - fb = XNOR reduction of out[i] over all i with TAPS[i]=1.
  - next = {fb, out[WIDTH-1:1]}.
- Advance: STEPS single shifts chained combinationally; out takes the final state.
- Start state:
  - Internal register; 0 after reset; updated to the loaded value on every load.
  - A wrap is any intermediate state s_1..s_STEPS of an advance equal to the start state.
- Lock-up:
  - All-ones is the XNOR lock-up state.
  - A load of all-ones stores all-zeros in both out and the start register, and pulses lockup_err.
- Priority: reset > load > enable.
  - load with enable high: load wins, no advance that cycle.
  - Neither asserted: state holds; bits_out holds; wrap and lockup_err are 0.
- Load:
  - bits_out is unchanged.
  - wrap is 0.
- Default parameters give a maximal sequence: x^10+x^7+1, period 1023.

## Timing
- All outputs registered; no combinational input-to-output path.
- Reset value of every output is 0: out, bits_out, wrap, lockup_err.
- Reset is asynchronous. Outputs go to 0 as soon as reset goes low, without a clock edge. The start register also clears to 0.
- Latency is one clock:
  - load at edge N: out = seed (or 0 for all-ones) after edge N.
  - enable at edge N: out = state advanced STEPS shifts after edge N.
- wrap and lockup_err:
  - Each rises on the same edge as the out update that causes it.
  - Each stays high exactly one cycle unless re-triggered on the next edge.
- Reset mid-run discards the sequence position. After release, the sequence restarts from 0 with start state 0.
- Simultaneous load and all-ones seed with enable: out=0, lockup_err=1, wrap=0.

## Structure
- Package lfsr_pkg:
  - function lfsr_next(state, taps), one shift;
  - constant DEFAULT_TAPS_10 = 10'b0000001001;
  - function all_ones(width).
- Sub-module lfsr_step:
  - One combinational shift stage with in state, out state and shifted-out bit.
  - lfsr_gen instantiates STEPS copies in a generate chain.
  - Each stage output is compared against the start register for wrap.
- Top-level holds three registers:
  - state,
  - start state,
  - the output pulse/bits registers.
- Parameter legality (TAPS[0], ranges) checked by elaboration-time assertions.

## Test plan
- Default params: reset low, release, enable high 3 cycles -> out 0x000, 0x200, 0x300, 0x380; bits_out 0 each cycle; wrap 0.
- Default params, enable held from reset:
  - wrap pulses exactly once, on enabled cycle 1023, with out == 0x000.
  - All 1023 states before it are distinct, none is 0x3FF, and wrap is 0 throughout.
- load=1, enable=1, seed=0x155 -> out 0x155 next cycle, no advance. Then 1023 enabled cycles -> wrap pulse with out == 0x155.
- load seed 0x3FF -> out 0x000, lockup_err high exactly one cycle. The next enabled cycle gives out 0x200.
- STEPS=4 instance:
  - first enabled cycle after reset -> out 0x3C0, bits_out 4'b0000;
  - wrap pulses on enabled cycle 256 (covers step 1023) and not before.
- Reset driven low mid-run, between clock edges -> out, bits_out, wrap, lockup_err all 0 immediately. After release, the sequence repeats 0x200, 0x300 from the start.
